i2s_tx_serializer: RTL and testbench

I2S master transmitter: the transmit-side counterpart of the I2S receiver path. It generates SCK/WS, pops PCM samples from a first-word-fall-through (FWFT) transmit FIFO, and serialises them MSB-first on SDO. It supports standard I2S and left-justified framing, 1–32-bit samples in fixed 32-bit slots, and mono or stereo channel selection, and it flags FIFO underruns. It sits between the TX FIFO (written by the bus wrapper) and the pads.

---
 rtl/i2s_tx_serializer.sv | 134 +++++++++++++
 tb/tb_i2s_tx_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_tx_serializer.sv
`timescale 1ns/1ps
// I2S master transmitter: generates SCK/WS, pops MSB-aligned samples from an
// FWFT TX FIFO at each slot boundary and shifts them out MSB-first on SDO in
// standard I2S or left-justified framing with fixed 32-bit slots.
module i2s_tx_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [7:0]  sck_prescaler,
  input  logic [5:0]  sample_size,
  input  logic        left_justified,
  input  logic [1:0]  channels,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_rdata,
  output logic        fifo_rd,
  output logic        sck,
  output logic        ws,
  output logic        sdo,
  output logic        underrun
);

  localparam int unsigned DataW = 32;
  localparam int unsigned PresW = 8;
  localparam int unsigned CtrW  = 5;
  localparam int unsigned SizeW = 6;

  logic [PresW-1:0] presc_q, presc_d;
  logic             sck_q, sck_d;
  logic [CtrW-1:0]  bit_ctr_q, bit_ctr_d;
  logic             ws_q, ws_d;
  logic [DataW-1:0] sr_q, sr_d;
  logic             d_lj_q, d_lj_d;
  logic             sdo_q, sdo_d;
  logic             lj_q, lj_d;
  logic             underrun_q, underrun_d;

  logic             tick;
  logic             fall_tick;
  logic             boundary;
  logic             chan_en;
  logic [SizeW-1:0] size_eff;
  logic [SizeW-1:0] shamt;
  logic [DataW-1:0] load_word;

  // Clamp the sample size and MSB-align the FIFO head word, zero-filling the tail.
  always_comb begin
    size_eff = sample_size;
    if ((sample_size == '0) || (sample_size > SizeW'(DataW))) begin
      size_eff = SizeW'(DataW);
    end
    shamt     = SizeW'(DataW) - size_eff;
    load_word = fifo_rdata << shamt;
  end

  // Prescaler/SCK generation, slot-boundary load, shifting and SDO framing.
  always_comb begin
    presc_d    = presc_q;
    sck_d      = sck_q;
    bit_ctr_d  = bit_ctr_q;
    ws_d       = ws_q;
    sr_d       = sr_q;
    d_lj_d     = d_lj_q;
    sdo_d      = sdo_q;
    lj_d       = lj_q;
    underrun_d = 1'b0;
    fifo_rd    = 1'b0;

    tick      = en && (presc_q == '0);
    fall_tick = tick && sck_q;
    boundary  = fall_tick && (bit_ctr_q == CtrW'(DataW - 1));
    // The new slot takes the inverted ws: leaving the right slot enters left.
    chan_en   = ws_q ? channels[1] : channels[0];

    if (en) begin
      if (tick) begin
        presc_d = sck_prescaler;
        sck_d   = ~sck_q;
      end else begin
        presc_d = presc_q - PresW'(1);
      end
    end

    if (fall_tick) begin
      bit_ctr_d = bit_ctr_q + CtrW'(1);
      if (boundary) begin
        ws_d = ~ws_q;
        lj_d = left_justified;
        if (chan_en && !fifo_empty) begin
          fifo_rd = 1'b1;
          sr_d    = load_word;
        end else begin
          sr_d       = '0;
          underrun_d = chan_en;
        end
      end else begin
        sr_d = {sr_q[DataW-2:0], 1'b0};
      end
      d_lj_d = sr_d[DataW-1];
      // Standard I2S emits the previous fall's bit, giving the one-SCK delay.
      sdo_d  = lj_d ? d_lj_d : d_lj_q;
    end
  end

  // State registers; ws idles on the right channel so the first slot is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sck_q      <= 1'b0;
      bit_ctr_q  <= '0;
      ws_q       <= 1'b1;
      sr_q       <= '0;
      d_lj_q     <= 1'b0;
      sdo_q      <= 1'b0;
      lj_q       <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sck_q      <= sck_d;
      bit_ctr_q  <= bit_ctr_d;
      ws_q       <= ws_d;
      sr_q       <= sr_d;
      d_lj_q     <= d_lj_d;
      sdo_q      <= sdo_d;
      lj_q       <= lj_d;
      underrun_q <= underrun_d;
    end
  end

  assign sck      = sck_q;
  assign ws       = ws_q;
  assign sdo      = sdo_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
`timescale 1ns/1ps
// Bench for i2s_tx_serializer: directed table of framing cases plus random
// configurations, all checked against a slot-level model of the bit stream.
module tb_i2s_tx_serializer;

  localparam int NSLOT = 7;
  localparam int NBITS = 32 * NSLOT;

  logic        clk = 1'b0;
  logic        rst_n, en, left_justified, fifo_empty;
  logic [7:0]  sck_prescaler;
  logic [5:0]  sample_size;
  logic [1:0]  channels;
  logic [31:0] fifo_rdata;
  logic        fifo_rd, sck, ws, sdo, underrun;

  int checks = 0;
  int errors = 0;

  // FIFO model (owned by the fifo process; main requests reloads by generation)
  logic [31:0] fifo_q[$];
  logic [31:0] load_words[$];
  int load_gen = 0;
  int load_done = 0;
  int rd_done = 0;

  // Monitor-owned observations
  bit rx_ws[$];
  bit rx_sdo[$];
  int n_rd = 0, n_ur = 0, rd_bad = 0, ur_wide = 0, per_bad = 0, rd_in_rst = 0;
  int rd_seen = 0, cyc = 0, last_rise = -1;
  logic sck_prev = 1'b0, ur_prev = 1'b0;
  bit per_chk = 1'b0;

  typedef struct {
    bit          lj;
    bit [1:0]    ch;
    bit [5:0]    ss;
    bit [7:0]    p;
    int          nw;
    logic [31:0] w0, w1, w2;
    int          mode;   // 0 plain, 1 en freeze mid-slot, 2 1-clk reset mid-slot
    logic [31:0] exp_l, exp_r;
    int          exp_rd, exp_ur;
  } vec_t;

  i2s_tx_serializer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sck_prescaler(sck_prescaler),
    .sample_size(sample_size), .left_justified(left_justified), .channels(channels),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata), .fifo_rd(fifo_rd),
    .sck(sck), .ws(ws), .sdo(sdo), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // FWFT FIFO: pops after the edge that consumed the head word.
  always @(posedge clk) begin
    logic [31:0] tmp;
    #1;
    if (load_done != load_gen) begin
      fifo_q    = load_words;
      load_done = load_gen;
      rd_done   = rd_seen;
    end else if (rd_done != rd_seen) begin
      if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      rd_done = rd_seen;
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 32'hFFFF_FFFF : fifo_q[0];
  end

  // Record (ws, sdo) at each SCK rise and protocol events on fifo_rd/underrun.
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_ws.delete();
      rx_sdo.delete();
      n_rd = 0; n_ur = 0; rd_bad = 0; ur_wide = 0; per_bad = 0;
      last_rise = -1; cyc = 0; sck_prev = 1'b0; ur_prev = 1'b0;
      if (fifo_rd || underrun) rd_in_rst++;
    end else begin
      cyc++;
      if (sck && !sck_prev) begin
        if (per_chk && last_rise >= 0 && (cyc - last_rise) != 2 * (int'(sck_prescaler) + 1))
          per_bad++;
        last_rise = cyc;
        rx_ws.push_back(ws);
        rx_sdo.push_back(sdo);
      end
      sck_prev = sck;
      if (fifo_rd) begin
        rd_seen++;
        if (rx_ws.size() < NBITS) begin
          n_rd++;
          if (underrun || rx_ws.size() == 0 || (rx_ws.size() % 32) != 0 || !channels[ws])
            rd_bad++;
        end
      end
      if (underrun) begin
        if (ur_prev) ur_wide++;
        if (rx_ws.size() < NBITS) n_ur++;
      end
      ur_prev = underrun;
    end
  end

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    end
  endtask

  task automatic run_case(input string name, input bit lj, input bit [1:0] ch,
                          input bit [5:0] ss, input bit [7:0] p, input int nw,
                          input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                          input int mode,
                          output logic [31:0] got_l, output logic [31:0] got_r,
                          output int rd, output int ur);
    logic [31:0] words[$];
    logic [31:0] mq[$];
    logic [31:0] sw[NSLOT];
    logic [31:0] g, e, gw;
    bit rx_s[$];
    bit rx_w[$];
    int budget, t, sz, exp_rd, exp_ur, off, c_bad, c_wide, c_per;
    bit frozen, rst_done, timed_out, bad, s0, w0s, d0;

    rst_n = 1'b0;
    en    = 1'b0;
    words = {};
    if (nw > 0) words.push_back(w0);
    if (nw > 1) words.push_back(w1);
    if (nw > 2) words.push_back(w2);
    load_words     = words;
    load_gen++;
    left_justified = lj;
    channels       = ch;
    sample_size    = ss;
    sck_prescaler  = p;
    per_chk        = (mode != 1);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;

    budget   = NSLOT * 64 * (int'(p) + 1) * 2 + 400;
    t        = 0;
    frozen   = 1'b0;
    rst_done = 1'b0;
    while (rx_ws.size() < NBITS && t < budget) begin
      @(negedge clk);
      #1;
      t++;
      if (mode == 1 && !frozen && rx_ws.size() >= 40) begin
        frozen = 1'b1;
        en  = 1'b0;
        s0  = sck; w0s = ws; d0 = sdo;
        bad = 1'b0;
        repeat (30) begin
          @(negedge clk);
          #1;
          if (sck !== s0 || ws !== w0s || sdo !== d0 || fifo_rd !== 1'b0 || underrun !== 1'b0)
            bad = 1'b1;
        end
        check32({name, ".freeze_changed"}, 32'(bad), 32'd0);
        en = 1'b1;
      end
      if (mode == 2 && !rst_done && rx_ws.size() >= 45) begin
        rst_done = 1'b1;
        rst_n    = 1'b0;
        #1;
        check32({name, ".rst_sck_ws_sdo_rd_ur"}, {27'd0, sck, ws, sdo, fifo_rd, underrun},
                32'b01000);
        @(negedge clk);
        #1;
        load_words = words;
        load_gen++;
        rst_n = 1'b1;
      end
    end

    timed_out = (rx_ws.size() < NBITS);
    rx_s   = rx_sdo;
    rx_w   = rx_ws;
    rd     = n_rd;
    ur     = n_ur;
    c_bad  = rd_bad;
    c_wide = ur_wide;
    c_per  = per_bad;
    rst_n  = 1'b0;
    en     = 1'b0;

    check32({name, ".timeout"}, 32'(timed_out), 32'd0);
    check32({name, ".rd_or_ur_in_reset"}, 32'(rd_in_rst), 32'd0);

    // Slot-level model: which word each slot carries, MSB-aligned.
    sz = (ss == 6'd0 || ss > 6'd32) ? 32 : int'(ss);
    mq = words;
    exp_rd = 0;
    exp_ur = 0;
    for (int s = 0; s < NSLOT; s++) begin
      bit wss, ena;
      wss   = (s % 2 == 0);
      ena   = (s == 0) ? 1'b0 : (wss ? ch[0] : ch[1]);
      sw[s] = 32'd0;
      if (ena) begin
        if (mq.size() > 0) begin
          sw[s] = mq.pop_front() << (32 - sz);
          exp_rd++;
        end else begin
          exp_ur++;
        end
      end
    end

    got_l = 32'd0;
    got_r = 32'd0;
    if (!timed_out) begin
      for (int s = 0; s < NSLOT; s++) begin
        g = 32'd0; e = 32'd0; gw = 32'd0;
        for (int k = 0; k < 32; k++) begin
          bit eb;
          if (lj) eb = sw[s][31-k];
          else if (k > 0) eb = sw[s][32-k];
          else if (s > 0) eb = sw[s-1][0];
          else eb = 1'b0;
          e[31-k]  = eb;
          g[31-k]  = rx_s[32*s+k];
          gw[31-k] = rx_w[32*s+k];
        end
        check32($sformatf("%s.slot%0d_sdo", name, s), g, e);
        check32($sformatf("%s.slot%0d_ws", name, s), gw, (s % 2 == 0) ? 32'hFFFF_FFFF : 32'd0);
      end
      check32({name, ".model_rd_count"}, 32'(rd), 32'(exp_rd));
      check32({name, ".model_ur_count"}, 32'(ur), 32'(exp_ur));
      check32({name, ".rd_misplaced"}, 32'(c_bad), 32'd0);
      check32({name, ".underrun_width"}, 32'(c_wide), 32'd0);
      if (mode != 1) check32({name, ".sck_period"}, 32'(c_per), 32'd0);
      off = lj ? 32 : 33;
      for (int k = 0; k < 32; k++) begin
        got_l[31-k] = rx_s[off+k];
        got_r[31-k] = rx_s[off+32+k];
      end
    end
  endtask

  initial begin
    vec_t tbl[10];
    logic [31:0] gl, gr;
    int rd, ur;

    rst_n = 1'b0; en = 1'b0; sck_prescaler = 8'd1; sample_size = 6'd16;
    left_justified = 1'b0; channels = 2'b00;

    repeat (3) @(negedge clk);
    #1;
    check32("reset_sck_ws_sdo_ur", {28'd0, sck, ws, sdo, underrun}, 32'b0100);

    //            lj  ch     ss     p     nw w0            w1            w2        mode exp_l         exp_r         rd ur
    tbl[0] = '{1'b1, 2'b11, 6'd16, 8'd1, 2, 32'h0000A5C3, 32'h00001234, 32'h0, 0, 32'hA5C30000, 32'h12340000, 2, 4};
    tbl[1] = '{1'b0, 2'b11, 6'd16, 8'd1, 2, 32'h0000A5C3, 32'h00001234, 32'h0, 1, 32'hA5C30000, 32'h12340000, 2, 4};
    tbl[2] = '{1'b0, 2'b10, 6'd32, 8'd1, 1, 32'h80000001, 32'h0,        32'h0, 2, 32'h80000001, 32'h00000000, 1, 2};
    tbl[3] = '{1'b1, 2'b10, 6'd8,  8'd0, 3, 32'h00000011, 32'h00000022, 32'h33, 0, 32'h11000000, 32'h00000000, 3, 0};
    tbl[4] = '{1'b0, 2'b01, 6'd24, 8'd1, 1, 32'h00ABCDEF, 32'h0,        32'h0, 0, 32'h00000000, 32'hABCDEF00, 1, 2};
    tbl[5] = '{1'b1, 2'b00, 6'd16, 8'd1, 1, 32'h00000001, 32'h0,        32'h0, 0, 32'h00000000, 32'h00000000, 0, 0};
    tbl[6] = '{1'b1, 2'b11, 6'd0,  8'd2, 2, 32'hDEADBEEF, 32'h12345678, 32'h0, 0, 32'hDEADBEEF, 32'h12345678, 2, 4};
    tbl[7] = '{1'b0, 2'b11, 6'd40, 8'd1, 2, 32'hDEADBEEF, 32'h12345678, 32'h0, 0, 32'hDEADBEEF, 32'h12345678, 2, 4};
    tbl[8] = '{1'b1, 2'b11, 6'd1,  8'd1, 2, 32'h00000001, 32'h00000003, 32'h0, 0, 32'h80000000, 32'h80000000, 2, 4};
    tbl[9] = '{1'b0, 2'b11, 6'd16, 8'd1, 0, 32'h0,        32'h0,        32'h0, 0, 32'h00000000, 32'h00000000, 0, 6};

    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      run_case(nm, tbl[i].lj, tbl[i].ch, tbl[i].ss, tbl[i].p, tbl[i].nw,
               tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].mode, gl, gr, rd, ur);
      check32({nm, ".left_word"}, gl, tbl[i].exp_l);
      check32({nm, ".right_word"}, gr, tbl[i].exp_r);
      check32({nm, ".fifo_rd_count"}, 32'(rd), 32'(tbl[i].exp_rd));
      check32({nm, ".underrun_count"}, 32'(ur), 32'(tbl[i].exp_ur));
    end

    for (int i = 0; i < 8; i++) begin
      run_case($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               6'($urandom_range(0, 40)), 8'($urandom_range(0, 3)), $urandom_range(0, 3),
               $urandom, $urandom, $urandom, 0, gl, gr, rd, ur);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
